hilo_unit: RTL and testbench

//  Architectural HI/LO register pair for MULT/MTHI/MTLO/MFHI/MFLO; sits directly upstream/downstream of multiplier_blk.

---
 rtl/hilo_if.sv | 30 +++
 rtl/hilo_unit.sv | 84 ++++++++
 tb/tb_hilo_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_if.sv
// hilo_if: op issue, HI/LO read and multiplier_blk request/response bundle for hilo_unit.
interface hilo_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             err;
  logic             mul_valid_in;
  logic             mul_lo_hi;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_result;
  logic             mul_valid_out;
  modport master (
    output op_valid, op_sel, op_a, op_b, rd_req, rd_sel, mul_result, mul_valid_out,
    input  op_ready, rd_data, rd_valid, stall, hi, lo, err, mul_valid_in, mul_lo_hi, mul_a, mul_b
  );
  modport slave (
    input  op_valid, op_sel, op_a, op_b, rd_req, rd_sel, mul_result, mul_valid_out,
    output op_ready, rd_data, rd_valid, stall, hi, lo, err, mul_valid_in, mul_lo_hi, mul_a, mul_b
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair; MULT runs as two multiplier_blk requests committed atomically.
// Define HILO_BYPASS_EN to let a stalled read complete from the multiplier result in the commit cycle.
module hilo_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_TIMEOUT = 16
) (
  input logic   clk,
  input logic   rst_n,
  hilo_if.slave bus
);
  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI} state_t;
  state_t           state;
  logic [WIDTH-1:0] hi, lo, lo_shadow, mul_a, mul_b;
  logic             err;
  logic [CW-1:0]    cnt;
  logic             timed_out;
  assign timed_out = cnt == CW'(MUL_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      lo_shadow <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.op_valid) begin
          if (bus.op_sel == 2'b00) begin
            mul_a <= bus.op_a;
            mul_b <= bus.op_b;
            state <= REQ_LO;
          end else if (bus.op_sel == 2'b01) hi <= bus.op_a;
          else if (bus.op_sel == 2'b10) lo <= bus.op_a;
        end
        REQ_LO: begin
          cnt   <= '0;
          state <= WAIT_LO;
        end
        WAIT_LO: if (bus.mul_valid_out) begin
          lo_shadow <= bus.mul_result;
          state     <= REQ_HI;
        end else if (timed_out) begin
          err   <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        REQ_HI: begin
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: if (bus.mul_valid_out) begin
          hi    <= bus.mul_result;
          lo    <= lo_shadow;
          state <= IDLE;
        end else if (timed_out) begin
          err   <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.op_ready     = state == IDLE;
  assign bus.mul_valid_in = state == REQ_LO || state == REQ_HI;
  assign bus.mul_lo_hi    = state == REQ_LO;
  assign bus.mul_a        = mul_a;
  assign bus.mul_b        = mul_b;
  assign bus.hi           = hi;
  assign bus.lo           = lo;
  assign bus.err          = err;
  assign bus.rd_valid     = bus.rd_req && !bus.stall;
`ifdef HILO_BYPASS_EN
  logic commit;
  assign commit      = state == WAIT_HI && bus.mul_valid_out;
  assign bus.stall   = bus.rd_req && state != IDLE && !commit;
  assign bus.rd_data = commit ? (bus.rd_sel ? bus.mul_result : lo_shadow) : (bus.rd_sel ? hi : lo);
`else
  assign bus.stall   = bus.rd_req && state != IDLE;
  assign bus.rd_data = bus.rd_sel ? hi : lo;
`endif
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: random and directed checks of hilo_unit against an architectural HI/LO model.
// A two-cycle multiplier_blk stand-in answers requests; reads are scored through an expected-data queue.
module tb_hilo_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hilo_if #(.WIDTH(32)) bus ();
  hilo_unit #(.WIDTH(32), .MUL_TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] exp_q[$];
  logic dead = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0;
  logic [31:0] r1 = '0, r2 = '0;
  int pulses = 0;
  logic lohi_q[$];
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction
  logic [63:0] prod;
  assign prod = smul(bus.mul_a, bus.mul_b);
  always @(posedge clk) begin
    d1 <= bus.mul_valid_in && !dead;
    r1 <= bus.mul_lo_hi ? prod[31:0] : prod[63:32];
    d2 <= d1;
    r2 <= r1;
  end
  assign bus.mul_valid_out = d2;
  assign bus.mul_result    = r2;
  always @(negedge clk) begin
    if (bus.mul_valid_in) begin
      pulses++;
      lohi_q.push_back(bus.mul_lo_hi);
    end
    if (bus.rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h with nothing expected", bus.rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", bus.rd_data, e);
        end
      end
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b, input bit upd);
    int n = 0;
    while (!bus.op_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.op_ready) begin
      total++;
      bad++;
      $display("FAIL op_ready_wait: got 0 expected 1 within 100 cycles");
    end
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.op_valid = 1'b0;
    if (upd) begin
      if (sel == 2'b00) {m_hi, m_lo} = smul(a, b);
      else if (sel == 2'b01) m_hi = a;
      else if (sel == 2'b10) m_lo = a;
    end
  endtask
  task automatic do_read(input logic sel, output int stalls);
    bit done = 0;
    exp_q.push_back(sel ? m_hi : m_lo);
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
    stalls = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.rd_valid) done = 1;
      else if (bus.stall) stalls++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL rd_wait: got no rd_valid expected one within 100 cycles");
    end
    tick();
    bus.rd_req = 1'b0;
  endtask
  task automatic mult_timed(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] old;
    old = {m_hi, m_lo};
    do_op(2'b00, a, b, 1);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("op_ready_T+%0d", i), bus.op_ready, 0);
      check($sformatf("hilo_hold_T+%0d", i), {bus.hi, bus.lo}, old);
      tick();
    end
    check("op_ready_T+7", bus.op_ready, 1);
    check("hilo_T+7", {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask
  initial begin
    int s;
    logic [63:0] old;
    int n;
    logic [1:0] seq;
    bus.op_valid = 0; bus.op_sel = 0; bus.op_a = 0; bus.op_b = 0;
    bus.rd_req = 0; bus.rd_sel = 0;
    #12;
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_err", bus.err, 0);
    check("rst_mul_valid_in", bus.mul_valid_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulses = 0;
    lohi_q.delete();
    mult_timed(32'h0001_0000, 32'h0001_0000);
    check("t1_pulses", pulses, 2);
    seq = (lohi_q.size() == 2) ? {lohi_q[0], lohi_q[1]} : 2'bxx;
    check("t1_lohi_seq", seq, 2'b10);
    mult_timed(32'hFFFF_FFFD, 32'h0000_0005);
    check("t2_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(2'b01, 32'hDEAD_BEEF, 0, 1);
    do_op(2'b10, 32'h1234_5678, 0, 1);
    do_read(1, s);
    check("t3_stall_hi", s, 0);
    do_read(0, s);
    check("t3_stall_lo", s, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 0, 1);
    check("t3_nop", {bus.hi, bus.lo}, 64'hDEAD_BEEF_1234_5678);
    do_op(2'b00, 7, 6, 1);
    do_read(1, s);
`ifdef HILO_BYPASS_EN
    check("t4_stall_cycles", s, 5);
`else
    check("t4_stall_cycles", s, 6);
`endif
    do_read(0, s);
    check("t4_lo42", bus.lo, 42);
    dead = 1'b1;
    old = {bus.hi, bus.lo};
    do_op(2'b00, 32'h1111, 32'h2222, 0);
    n = 0;
    while (!bus.op_ready && n < 100) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", n, 17);
    check("t5_err", bus.err, 1);
    check("t5_hilo", {bus.hi, bus.lo}, old);
    dead = 1'b0;
    do_op(2'b10, 32'h1, 0, 1);
    check("t5_mtlo", bus.lo, 1);
    check("t5_err_sticky", bus.err, 1);
    do_op(2'b01, 32'hA5A5_5A5A, 0, 1);
    do_op(2'b00, 5, 9, 0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("t6_hilo", {bus.hi, bus.lo}, 64'd0);
    check("t6_mul_valid_in", bus.mul_valid_in, 0);
    check("t6_op_ready", bus.op_ready, 1);
    check("t6_err", bus.err, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mult_timed(2, 3);
    do_read(0, s);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sel;
      logic [31:0] a, b;
      sel = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 10 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 10 : $urandom;
      do_op(sel, a, b, 1);
      if ($urandom_range(0, 1) == 1) do_read(1'($urandom_range(0, 1)), s);
    end
    do_read(1, s);
    do_read(0, s);
    check("final_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
